// File: rtl/spi_master_gen.sv
// SPI master with parameterised word width, divider, shift order and slave count.
// Mode {CPOL,CPHA} and target slave are latched per transfer; all outputs are registered.
module spi_master_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 3,
    parameter int SS_WIDTH   = 2,
    parameter int CLK_DIV    = 1,
    parameter int LSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [SS_WIDTH-1:0]   SlaveSelect,
    input  logic [1:0]            Mode,
    input  logic [DATA_WIDTH-1:0] DataToSlave,
    output logic [DATA_WIDTH-1:0] DataReceived,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err,
    output logic                  Sclk,
    output logic [NUM_SLAVES-1:0] Cs,
    output logic                  Mosi,
    input  logic                  Miso
);

    localparam int HPW = $clog2(2 * DATA_WIDTH);
    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [HPW-1:0]   HP_LAST  = HPW'(2 * DATA_WIDTH - 1);
    localparam logic [HPW-1:0]   HP_NOADV = HPW'(2 * DATA_WIDTH - 2);
    localparam logic [SS_WIDTH:0] NSL     = (SS_WIDTH + 1)'(NUM_SLAVES);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DONE} state_t;

    state_t                state_q;
    logic [7:0]            div_q;
    logic [HPW-1:0]        hp_q;
    logic                  cpol_q, cpha_q;
    logic [DATA_WIDTH-1:0] tx_q, rx_q, rdata_q;
    logic [NUM_SLAVES-1:0] cs_q, cs_sel_d;
    logic                  sclk_q, mosi_q, busy_q, done_q, err_q;
    logic                  sel_ok_d, div_wrap_d;

    function automatic logic out_bit(input logic [DATA_WIDTH-1:0] v);
        return (LSB_FIRST != 0) ? v[0] : v[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] v);
        return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
    endfunction

    // First sampled bit ends up in bit 0 (LSB-first) or bit DATA_WIDTH-1 (MSB-first).
    function automatic logic [DATA_WIDTH-1:0] shift_rx(input logic [DATA_WIDTH-1:0] v,
                                                       input logic b);
        return (LSB_FIRST != 0) ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
    endfunction

    assign sel_ok_d   = ({1'b0, SlaveSelect} < NSL);
    assign div_wrap_d = (div_q == DIV_LAST);

    always_comb begin
        cs_sel_d = '1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (SlaveSelect == SS_WIDTH'(i)) cs_sel_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            hp_q    <= '0;
            cs_q    <= '1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        if (sel_ok_d) begin
                            state_q <= LEAD;
                            div_q   <= '0;
                            hp_q    <= '0;
                            cs_q    <= cs_sel_d;
                            cpol_q  <= Mode[1];
                            cpha_q  <= Mode[0];
                            sclk_q  <= Mode[1];
                            tx_q    <= DataToSlave;
                            mosi_q  <= out_bit(DataToSlave);
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LEAD: begin
                    if (div_wrap_d) begin
                        div_q   <= '0;
                        state_q <= SHIFT;
                        sclk_q  <= ~cpol_q;
                        if (!cpha_q) rx_q <= shift_rx(rx_q, Miso);
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                SHIFT: begin
                    if (div_wrap_d) begin
                        div_q <= '0;
                        if (hp_q == HP_LAST) begin
                            state_q <= TRAIL;
                            sclk_q  <= cpol_q;
                        end else begin
                            hp_q   <= hp_q + 1'b1;
                            sclk_q <= ~sclk_q;
                            // odd hp_q means the next half-period starts with a leading edge
                            if (hp_q[0]) begin
                                if (cpha_q) begin
                                    tx_q   <= shift_tx(tx_q);
                                    mosi_q <= out_bit(shift_tx(tx_q));
                                end else begin
                                    rx_q <= shift_rx(rx_q, Miso);
                                end
                            end else begin
                                if (cpha_q) begin
                                    rx_q <= shift_rx(rx_q, Miso);
                                end else if (hp_q != HP_NOADV) begin
                                    tx_q   <= shift_tx(tx_q);
                                    mosi_q <= out_bit(shift_tx(tx_q));
                                end
                            end
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                TRAIL: begin
                    if (div_wrap_d) begin
                        div_q   <= '0;
                        state_q <= DONE;
                        cs_q    <= '1;
                        done_q  <= 1'b1;
                        rdata_q <= rx_q;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DataReceived = rdata_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Err          = err_q;
    assign Sclk         = sclk_q;
    assign Cs           = cs_q;
    assign Mosi         = mosi_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: default instance against an SPI slave model, and a
// 16-bit MSB-first divide-by-3 instance with Miso looped back to Mosi.
module tb_spi_master_gen;

    typedef struct {
        logic [31:0] tx;
        logic [31:0] rx;
        int          done_cyc;
        logic [1:0]  mode;
        logic [2:0]  cs;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: defaults
    logic       start_a, busy_a, done_a, err_a, sclk_a, mosi_a, miso_a;
    logic [1:0] sel_a, mode_a;
    logic [7:0] dts_a, dr_a;
    logic [2:0] cs_a;
    // instance B: 16-bit, H=3, MSB-first, loopback
    logic        start_b, busy_b, done_b, err_b, sclk_b, mosi_b, miso_b;
    logic [1:0]  sel_b, mode_b;
    logic [15:0] dts_b, dr_b;
    logic [2:0]  cs_b;
    assign miso_b = mosi_b;

    spi_master_gen #(.DATA_WIDTH(8), .NUM_SLAVES(3), .SS_WIDTH(2), .CLK_DIV(1), .LSB_FIRST(1)) dut_a (
        .clk(clk), .Reset(rst), .Start(start_a), .SlaveSelect(sel_a), .Mode(mode_a),
        .DataToSlave(dts_a), .DataReceived(dr_a), .Busy(busy_a), .Done(done_a), .Err(err_a),
        .Sclk(sclk_a), .Cs(cs_a), .Mosi(mosi_a), .Miso(miso_a));

    spi_master_gen #(.DATA_WIDTH(16), .NUM_SLAVES(3), .SS_WIDTH(2), .CLK_DIV(3), .LSB_FIRST(0)) dut_b (
        .clk(clk), .Reset(rst), .Start(start_b), .SlaveSelect(sel_b), .Mode(mode_b),
        .DataToSlave(dts_b), .DataReceived(dr_b), .Busy(busy_b), .Done(done_b), .Err(err_b),
        .Sclk(sclk_b), .Cs(cs_b), .Mosi(mosi_b), .Miso(miso_b));

    exp_t qa[$];
    exp_t qb[$];
    int   qea[$];
    int   qeb[$];

    // slave model state for instance A
    logic [1:0] slv_mode_a;
    logic [7:0] slv_miso_a;
    logic [7:0] slv_word_a;
    int         slv_cnt_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] cs_pat(input logic [1:0] sel);
        logic [2:0] c;
        c = 3'b111;
        for (int i = 0; i < 3; i++) if (int'(sel) == i) c[i] = 1'b0;
        return c;
    endfunction

    // Behavioural SPI slave (LSB-first) for instance A: shifts its word out on Miso and
    // captures Mosi, following the edge rules of the latched mode.
    initial begin
        logic ps;
        bit   pact, lead;
        int   nin, nout;
        logic [7:0] cap;
        ps = 1'b0; pact = 0; nin = 0; nout = 0; cap = '0;
        miso_a = 1'b0; slv_word_a = '0; slv_cnt_a = 0;
        forever begin
            @(posedge clk);
            #2;
            if (cs_a != 3'b111) begin
                if (!pact) begin
                    nin = 0; nout = 0; cap = '0;
                    if (!slv_mode_a[0]) begin
                        miso_a = slv_miso_a[0];
                        nout = 1;
                    end
                end else if (sclk_a != ps) begin
                    lead = (sclk_a != slv_mode_a[1]);
                    if (lead ^ slv_mode_a[0]) begin
                        if (nin < 8) cap[nin] = mosi_a;
                        nin++;
                    end else if (nout < 8) begin
                        miso_a = slv_miso_a[nout];
                        nout++;
                    end
                end
                ps = sclk_a;
                pact = 1;
            end else begin
                if (pact) begin
                    slv_word_a = cap;
                    slv_cnt_a  = nin;
                end
                pact = 0;
            end
        end
    end

    // Monitor A
    initial begin
        exp_t e;
        logic idle_cpol;
        logic [7:0] prev_dr;
        bit prev_rst;
        idle_cpol = 1'b0; prev_dr = '0; prev_rst = 1;
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                chk("A reset Cs", 32'(cs_a), 32'h7);
                chk("A reset Busy/Done/Err", {29'b0, busy_a, done_a, err_a}, 32'h0);
                chk("A reset Sclk/Mosi", {30'b0, sclk_a, mosi_a}, 32'h0);
                chk("A reset DataReceived", 32'(dr_a), 32'h0);
            end else begin
                if (done_a) begin
                    if (qa.size() == 0) chk("A unexpected Done", 32'(done_a), 32'h0);
                    else begin
                        e = qa.pop_front();
                        chk("A Done cycle", cyc, e.done_cyc);
                        chk("A DataReceived", 32'(dr_a), e.rx);
                        chk("A Mosi word", 32'(slv_word_a), e.tx);
                        chk("A Mosi bit count", slv_cnt_a, 8);
                        chk("A Busy at Done", 32'(busy_a), 32'h1);
                        chk("A Cs at Done", 32'(cs_a), 32'h7);
                        idle_cpol = e.mode[1];
                    end
                end else begin
                    chk("A DataReceived hold", 32'(dr_a), 32'(prev_dr));
                    if (busy_a && qa.size() > 0) chk("A Cs in transfer", 32'(cs_a), 32'(qa[0].cs));
                    if (!busy_a) begin
                        chk("A Sclk idle", 32'(sclk_a), 32'(idle_cpol));
                        chk("A Cs idle", 32'(cs_a), 32'h7);
                    end
                end
                if (err_a) begin
                    if (qea.size() == 0) chk("A unexpected Err", 32'(err_a), 32'h0);
                    else chk("A Err cycle", cyc, qea.pop_front());
                end
            end
            prev_dr = dr_a;
            prev_rst = rst;
            if (rst) idle_cpol = 1'b0;
        end
    end

    // Monitor B
    initial begin
        exp_t e;
        logic idle_cpol;
        logic [15:0] prev_dr;
        bit prev_rst;
        idle_cpol = 1'b0; prev_dr = '0; prev_rst = 1;
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                chk("B reset Cs", 32'(cs_b), 32'h7);
                chk("B reset Busy/Done/Err", {29'b0, busy_b, done_b, err_b}, 32'h0);
                chk("B reset DataReceived", 32'(dr_b), 32'h0);
            end else begin
                if (done_b) begin
                    if (qb.size() == 0) chk("B unexpected Done", 32'(done_b), 32'h0);
                    else begin
                        e = qb.pop_front();
                        chk("B Done cycle", cyc, e.done_cyc);
                        chk("B DataReceived", 32'(dr_b), e.rx);
                        chk("B Cs at Done", 32'(cs_b), 32'h7);
                        idle_cpol = e.mode[1];
                    end
                end else begin
                    chk("B DataReceived hold", 32'(dr_b), 32'(prev_dr));
                    if (busy_b && qb.size() > 0) chk("B Cs in transfer", 32'(cs_b), 32'(qb[0].cs));
                    if (!busy_b) chk("B Sclk idle", 32'(sclk_b), 32'(idle_cpol));
                end
                if (err_b) begin
                    if (qeb.size() == 0) chk("B unexpected Err", 32'(err_b), 32'h0);
                    else chk("B Err cycle", cyc, qeb.pop_front());
                end
            end
            prev_dr = dr_b;
            prev_rst = rst;
            if (rst) idle_cpol = 1'b0;
        end
    end

    task automatic wait_idle_a(input string name);
        for (int i = 0; i < 60; i++) begin
            if (!busy_a) break;
            @(posedge clk); #1;
        end
        if (busy_a) chk(name, 32'(busy_a), 32'h0);
    endtask

    task automatic wait_idle_b(input string name);
        for (int i = 0; i < 200; i++) begin
            if (!busy_b) break;
            @(posedge clk); #1;
        end
        if (busy_b) chk(name, 32'(busy_b), 32'h0);
    endtask

    // Issue one Start in the current cycle (cycle 0) and push the expected outcome.
    task automatic xfer_a(input logic [1:0] sel, input logic [1:0] mode,
                          input logic [7:0] tx, input logic [7:0] rxw);
        exp_t e;
        slv_mode_a = mode; slv_miso_a = rxw;
        sel_a = sel; mode_a = mode; dts_a = tx; start_a = 1'b1;
        if (sel < 2'd3) begin
            e.tx = 32'(tx); e.rx = 32'(rxw); e.mode = mode; e.cs = cs_pat(sel);
            e.done_cyc = cyc + 19;
            qa.push_back(e);
        end else begin
            qea.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        start_a = 1'b0;
        dts_a = 8'($urandom); mode_a = 2'($urandom); sel_a = 2'($urandom);
        wait_idle_a("A transfer timeout");
    endtask

    task automatic xfer_b(input logic [1:0] sel, input logic [1:0] mode, input logic [15:0] tx);
        exp_t e;
        sel_b = sel; mode_b = mode; dts_b = tx; start_b = 1'b1;
        e.tx = 32'(tx); e.rx = 32'(tx); e.mode = mode; e.cs = cs_pat(sel);
        e.done_cyc = cyc + 103;
        qb.push_back(e);
        @(posedge clk); #1;
        start_b = 1'b0;
        dts_b = 16'($urandom); mode_b = 2'($urandom); sel_b = 2'($urandom);
        wait_idle_b("B transfer timeout");
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        start_a = 1'b0; sel_a = '0; mode_a = '0; dts_a = '0;
        start_b = 1'b0; sel_b = '0; mode_b = '0; dts_b = '0;
        slv_mode_a = '0; slv_miso_a = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // reference transfer: Mosi 1,1,1,1,1,0,1,0 and Miso 8'h57
        xfer_a(2'd1, 2'b00, 8'h5F, 8'h57);
        // all modes, then an out-of-range select
        for (int m = 0; m < 4; m++) xfer_a(2'(m % 3), 2'(m), 8'($urandom), 8'($urandom));
        xfer_a(2'd3, 2'b00, 8'hAA, 8'h00);
        @(posedge clk); #1;
        chk("A Busy after Err", 32'(busy_a), 32'h0);
        for (int i = 0; i < 10; i++)
            xfer_a(2'($urandom_range(0, 2)), 2'($urandom), 8'($urandom), 8'($urandom));

        // Start held high: second acceptance lands one cycle after Done
        slv_mode_a = 2'b01; slv_miso_a = 8'hC6;
        sel_a = 2'd2; mode_a = 2'b01; dts_a = 8'h3C; start_a = 1'b1;
        e.tx = 32'h3C; e.rx = 32'hC6; e.mode = 2'b01; e.cs = cs_pat(2'd2); e.done_cyc = cyc + 19;
        qa.push_back(e);
        e.tx = 32'h81; e.done_cyc = cyc + 39;
        qa.push_back(e);
        @(posedge clk); #1;
        dts_a = 8'h81;
        repeat (20) @(posedge clk);
        #1 start_a = 1'b0;
        wait_idle_a("A held-start timeout");

        // reset at cycle 7 of a CPOL=1 transfer
        slv_mode_a = 2'b11; slv_miso_a = 8'h0F;
        sel_a = 2'd0; mode_a = 2'b11; dts_a = 8'h99; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start_a = 1'b0;
        chk("A abort Cs", 32'(cs_a), 32'h7);
        chk("A abort Busy", 32'(busy_a), 32'h0);
        chk("A abort DataReceived", 32'(dr_a), 32'h0);
        repeat (25) @(posedge clk);
        #1;

        // instance B: every mode with 16'hA5C3, then random words
        for (int m = 0; m < 4; m++) xfer_b(2'(m % 3), 2'(m), 16'hA5C3);
        for (int i = 0; i < 3; i++)
            xfer_b(2'($urandom_range(0, 2)), 2'($urandom), 16'($urandom));

        repeat (5) @(posedge clk);
        #1;
        chk("A pending transfers", qa.size(), 0);
        chk("B pending transfers", qb.size(), 0);
        chk("A pending Err", qea.size(), 0);
        chk("B pending Err", qeb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
